usrt_tx_framer: RTL
===================

Name: usrt_tx_framer

Overview:
- Parametrised transmit framer and serialiser for the USRT transmit path.
- Accepts a data word over a valid/ready handshake and computes the parity bit (none/even/odd/mark).
- Builds a frame of start bit, data, optional parity and 1 or 2 stop bits, and shifts it out LSB-first, one bit per i_BitEn tick.
- Also presents the packed frame in parallel on o_Frame for loopback and debug.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FRAME_W, DATA_W+4, packed frame width; derived, must not be overridden.

Ports:
i_Pclk  in  1  clock; all logic on rising edge.
i_Rst_n  in  1  asynchronous, active-low reset.
i_BitEn  in  1  bit-period strobe, one i_Pclk cycle wide; each line bit lasts from one strobe to the next.
i_Valid  in  1  i_Data/i_Parity/i_TwoStop valid.
o_Ready  out  1  framer can accept a word.
i_Data  in  DATA_W  payload, transmitted LSB first.
i_Parity  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit always 1).
i_TwoStop  in  1  1 = two stop bits, 0 = one.
o_Tx  out  1  serial line; idle high.
o_Busy  out  1  frame in progress.
o_Done  out  1  one-cycle pulse when the final stop bit completes.
o_Frame  out  FRAME_W  packed frame latched at accept.

Behaviour:
- Reset (async, i_Rst_n=0):
  - State IDLE; o_Tx=1, o_Ready=1, o_Busy=0, o_Done=0, o_Frame all ones.
  - Applies immediately mid-frame; the line returns high with no glitch low.
- Accept: i_Valid & o_Ready on a rising edge.
  - Latch data and mode into internal registers.
  - Next cycle: o_Ready=0, o_Busy=1, o_Tx=0 (start bit), state START.
  - Inputs are sampled only at accept; later changes have no effect on the frame in flight.
- Parity: computed at accept from i_Data.
  - even = XOR of data bits.
  - odd = inverted XOR.
  - mark = 1.
  - none = no parity bit on the line.
- o_Frame layout (latched at accept):
  - bit0 = start (0).
  - bits[DATA_W:1] = data.
  - bit[DATA_W+1] = parity (1 when mode none).
  - bit[DATA_W+2] = stop1 (1).
  - bit[DATA_W+3] = stop2 (always 1; not sent when i_TwoStop=0).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Every transition except IDLE->START happens only on a cycle with i_BitEn=1.
  - START -> DATA.
  - DATA: bit counter 0..DATA_W-1; o_Tx = data[cnt]. At cnt=DATA_W-1, go to PARITY if mode != none, else to STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if two-stop, else IDLE.
  - STOP2 -> IDLE.
  - o_Tx updates on the cycle after the strobe, i.e. it is registered.
- Bit timing:
  - An i_BitEn coincident with the accept edge is ignored.
  - The start bit ends on the first strobe after accept.
  - Each state consumes exactly one strobe; DATA consumes DATA_W strobes.
- Frame length in strobes: 1 + DATA_W + (parity?1:0) + (two-stop?2:1).
- Completion: on the strobe that ends the last stop bit:
  - State returns to IDLE; o_Done=1 for one cycle.
  - o_Ready=1 and o_Busy=0 in that same next cycle.
  - o_Tx stays 1.
- Back-to-back:
  - i_Valid held high is accepted in the first IDLE cycle.
  - Exactly one idle-high cycle separates consecutive frames at the i_Pclk level. No extra bit period is inserted when the next accept precedes the next strobe.
- i_Valid while busy: ignored and not queued.
- i_BitEn in IDLE: no effect.
- The bit counter is $clog2(DATA_W) bits wide and never wraps past DATA_W-1.

Test Plan:
- Reset, then i_Data=8'hA5, parity 01, one stop, i_BitEn every 4 cycles -> o_Frame=12'hD4A; o_Tx sequence 0,1,0,1,0,0,1,0,1,0,1 each held 4 cycles; o_Done pulses once after 11 strobes.
- i_Data=8'h07, parity 10 -> parity bit 0; same data with parity 01 -> parity bit 1; parity 11 -> 1.
- i_Data=8'hA5, parity 00, i_TwoStop=1 -> o_Frame=12'hF4A; line shows start, 8 data, 2 stop = 11 strobes; no parity bit on line.
- DATA_W=7, i_Data=7'h55, parity 10, two stop -> parity 1; 11 strobes; o_Frame=11'h7AA.
- i_Rst_n asserted during DATA bit 3 -> o_Tx=1, o_Ready=1, o_Busy=0 asynchronously; next accept sends a clean full frame.
- i_Valid held high with i_Data changing while busy -> only the first word is sent; second word accepted in the first IDLE cycle after o_Done; i_BitEn coincident with accept is ignored (start bit spans a full period).

Source files
------------

// File: rtl/usrt_tx_framer.sv
// USRT transmit framer: accepts a word over valid/ready, builds start/data/parity/stop
// framing and shifts it out LSB-first, one line bit per i_BitEn strobe.
module usrt_tx_framer #(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = DATA_W + 4
) (
    input  logic               i_Pclk,
    input  logic               i_Rst_n,
    input  logic               i_BitEn,
    input  logic               i_Valid,
    output logic               o_Ready,
    input  logic [DATA_W-1:0]  i_Data,
    input  logic [1:0]         i_Parity,
    input  logic               i_TwoStop,
    output logic               o_Tx,
    output logic               o_Busy,
    output logic               o_Done,
    output logic [FRAME_W-1:0] o_Frame
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_e;

    // Parity bit for the selected mode; "none" places a 1 in the frame slot.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            2'b01:   p = ^data;
            2'b10:   p = ~(^data);
            2'b11:   p = 1'b1;
            default: p = 1'b1;
        endcase
        return p;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               par_en_q, par_en_d;
    logic               two_stop_q, two_stop_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  data_s;

    assign data_s = frame_q[DATA_W:1];

    // State and output registers; reset forces the line high immediately.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_q    <= '1;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic: accept in IDLE, otherwise advance one state per strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_Valid) begin
                    frame_d    = {1'b1, 1'b1, parity_bit(i_Data, i_Parity), i_Data, 1'b0};
                    par_en_d   = (i_Parity != 2'b00);
                    two_stop_d = i_TwoStop;
                    cnt_d      = '0;
                    state_d    = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_BitEn) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (i_BitEn) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (i_BitEn) begin
                    state_d = ST_STOP1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (i_BitEn) begin
                    state_d = two_stop_q ? ST_STOP2 : ST_IDLE;
                    done_d  = ~two_stop_q;
                end else begin
                    state_d = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (i_BitEn) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line value for the upcoming state; START needs no frame data so accept timing is safe.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_s[cnt_d];
            ST_PARITY: tx_d = frame_q[DATA_W+1];
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    assign o_Tx    = tx_q;
    assign o_Ready = ready_q;
    assign o_Busy  = busy_q;
    assign o_Done  = done_q;
    assign o_Frame = frame_q;

endmodule
